// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and helpers for the register file write arbiter
//
// Contents:
//   arb_state_t : FSM state type (ST_INIT sweep, ST_RUN arbitrate)
//   pack_lsb()  : LSB position of entry idx inside a packed per-requester bus
package rf_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  localparam int RF_ARB_MAX_REQ = 8;

  function automatic int pack_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with rotating priority pointer
//
// Parameters:
//   NUM_REQ : number of requesters (2..8)
// Ports:
//   req     in  NUM_REQ        request vector
//   rr_ptr  in  clog2(NUM_REQ) index with highest priority this cycle
//   gnt     out NUM_REQ        one-hot grant, zero when req is zero
//   gnt_idx out clog2(NUM_REQ) binary index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic found;

  // Scan upward from rr_ptr, wrapping at NUM_REQ; first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        gnt_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// rtl/reg_file_wr_arbiter.sv - round-robin sharing of the register file write port
//
// Optional feature macro: RF_ARB_INIT_EN (post-reset sweep writing INIT_VALUE to
// every entry before any requester is granted).
//
// Parameters: DATA_WIDTH, ADDR_WIDTH, NUM_REQ (2..8), INIT_VALUE
// Ports:
//   clk        in  1                      clock, rising edge
//   reset_n    in  1                      asynchronous active-low reset
//   req        in  NUM_REQ                per-requester write request
//   req_addr   in  NUM_REQ*ADDR_WIDTH     packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   in  NUM_REQ*DATA_WIDTH     packed data, same packing
//   gnt        out NUM_REQ                one-hot grant, combinational
//   busy       out 1                      high while the init sweep runs
//   rf_wr_en   out 1                      registered register file write enable
//   rf_w_addr  out ADDR_WIDTH             registered register file write address
//   rf_w_data  out DATA_WIDTH             registered register file write data
module reg_file_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    NUM_REQ    = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             busy,
  output logic                             rf_wr_en,
  output logic [ADDR_WIDTH-1:0]            rf_w_addr,
  output logic [DATA_WIDTH-1:0]            rf_w_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  run;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [PTR_W-1:0]      next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef RF_ARB_INIT_EN
  arb_state_t            state;
  logic [ADDR_WIDTH-1:0] init_cnt;

  assign run  = (state == ST_RUN);
  assign busy = ~run;
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Requests seen during the sweep stay pending at the requester; they are
  // simply masked here and picked up once the FSM reaches ST_RUN.
  assign gnt  = run ? arb_gnt : '0;
  assign xfer = |gnt;

  assign sel_addr = req_addr[pack_lsb(int'(gnt_idx), ADDR_WIDTH) +: ADDR_WIDTH];
  assign sel_data = req_data[pack_lsb(int'(gnt_idx), DATA_WIDTH) +: DATA_WIDTH];

  // Priority moves to the requester just after the winner.
  assign next_ptr = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en  <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      rr_ptr    <= '0;
`ifdef RF_ARB_INIT_EN
      state     <= ST_INIT;
      init_cnt  <= '0;
`endif
    end else begin
`ifdef RF_ARB_INIT_EN
      if (state == ST_INIT) begin
        rf_wr_en  <= 1'b1;
        rf_w_addr <= init_cnt;
        rf_w_data <= INIT_VALUE;
        init_cnt  <= init_cnt + ADDR_WIDTH'(1);
        // Last entry issued this cycle; arbitration starts next cycle.
        if (init_cnt == '1) begin
          state <= ST_RUN;
        end
      end else begin
`else
      begin
`endif
        rf_wr_en <= xfer;
        if (xfer) begin
          rf_w_addr <= sel_addr;
          rf_w_data <= sel_data;
          rr_ptr    <= next_ptr;
        end
      end
    end
  end

endmodule
